// File: rtl/lcd_spi_phy.sv
// LCD panel physical layer: timed hardware-reset sequence and 9-bit (D/C + byte) SPI mode-0 writes.
// Every panel pin and status output is registered; done_o pulses one cycle at command completion.
module lcd_spi_phy #(
  parameter int unsigned CLK_DIV      = 2,
  parameter int unsigned RST_LOW_CYC  = 50_000,
  parameter int unsigned RST_WAIT_CYC = 6_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] en_i,
  input  logic [8:0] data_i,
  output logic [1:0] done_o,
  output logic       busy_o,
  output logic       lcd_rst_o,
  output logic       lcd_cs_o,
  output logic       lcd_dc_o,
  output logic       lcd_sclk_o,
  output logic       lcd_mosi_o
);

  localparam int unsigned MAX_A   = (CLK_DIV > RST_LOW_CYC) ? CLK_DIV : RST_LOW_CYC;
  localparam int unsigned MAX_CYC = (MAX_A > RST_WAIT_CYC) ? MAX_A : RST_WAIT_CYC;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] LOW_LAST  = CNT_W'(RST_LOW_CYC - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RST_WAIT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    RST_LOW,
    RST_WAIT,
    TX_SHIFT,
    TX_HOLD
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [6:0]       sh_q, sh_d;
  logic [1:0]       done_d;
  logic             busy_d, rst_d, cs_d, dc_d, sclk_d, mosi_d;

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      sh_q       <= '0;
      done_o     <= '0;
      busy_o     <= 1'b0;
      lcd_rst_o  <= 1'b1;
      lcd_cs_o   <= 1'b1;
      lcd_dc_o   <= 1'b0;
      lcd_sclk_o <= 1'b0;
      lcd_mosi_o <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      sh_q       <= sh_d;
      done_o     <= done_d;
      busy_o     <= busy_d;
      lcd_rst_o  <= rst_d;
      lcd_cs_o   <= cs_d;
      lcd_dc_o   <= dc_d;
      lcd_sclk_o <= sclk_d;
      lcd_mosi_o <= mosi_d;
    end
  end

  // Next state and next output values
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    bit_d   = bit_q;
    sh_d    = sh_q;
    done_d  = 2'b00;
    busy_d  = busy_o;
    rst_d   = lcd_rst_o;
    cs_d    = lcd_cs_o;
    dc_d    = lcd_dc_o;
    sclk_d  = lcd_sclk_o;
    mosi_d  = lcd_mosi_o;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // Reset takes priority over a simultaneous write request
        if (en_i[0]) begin
          state_d = RST_LOW;
          rst_d   = 1'b0;
          busy_d  = 1'b1;
        end else if (en_i[1]) begin
          state_d = TX_SHIFT;
          cs_d    = 1'b0;
          dc_d    = data_i[8];
          mosi_d  = data_i[7];
          sh_d    = data_i[6:0];
          bit_d   = 3'd7;
          sclk_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end

      RST_LOW: begin
        if (cnt_q == LOW_LAST) begin
          state_d = RST_WAIT;
          rst_d   = 1'b1;
          cnt_d   = '0;
        end
      end

      RST_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = IDLE;
          done_d  = 2'b01;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end
      end

      TX_SHIFT: begin
        // Half-period boundary: rise mid-bit, fall presents the next bit
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (!lcd_sclk_o) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bit_q == 3'd0) begin
              state_d = TX_HOLD;
            end else begin
              bit_d  = bit_q - 3'd1;
              mosi_d = sh_q[6];
              sh_d   = {sh_q[5:0], 1'b0};
            end
          end
        end
      end

      TX_HOLD: begin
        if (cnt_q == DIV_LAST) begin
          state_d = IDLE;
          cs_d    = 1'b1;
          done_d  = 2'b10;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: doc/lcd_spi_phy.md
# lcd_spi_phy

Physical-layer engine between the LCD sequencing FSM and the panel pins. It executes two one-cycle commands from the sequencer: a timed hardware-reset sequence and a single 9-bit SPI write (D/C flag plus 8 data bits). It reports completion of each command with a one-cycle done pulse. It owns all panel I/O: RES, CS, DC, SCLK, MOSI.

## Interface
- CLK_DIV, 2: clk cycles per SCLK half-period, legal range ≥1.
- RST_LOW_CYC, 50_000: clk cycles lcd_rst_o is held low (1 ms at 50 MHz), legal range ≥1.
- RST_WAIT_CYC, 6_000_000: clk cycles waited after lcd_rst_o rises before done (120 ms at 50 MHz), legal range ≥1.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- en_i  in  2  command strobes. Bit0 starts the panel reset sequence; bit1 starts an SPI write.
- data_i  in  9  write payload. Bit8 is D/C (0 = command, 1 = data); bits 7:0 are the byte, sent MSB first.
- done_o  out  2  one-cycle completion pulses. Bit0 marks end of reset; bit1 marks end of write.
- busy_o  out  1  high while a command is executing.
- lcd_rst_o  out  1  panel RES, active low.
- lcd_cs_o  out  1  panel chip select, active low.
- lcd_dc_o  out  1  panel D/C.
- lcd_sclk_o  out  1  SPI clock, mode 0 (idle low).
- lcd_mosi_o  out  1  SPI data.

## Operation
- States: IDLE, RST_LOW, RST_WAIT, TX_SHIFT, TX_HOLD. All outputs are registered.
- **IDLE**
  - en_i is sampled only in IDLE and ignored in every other state.
  - en_i[0] → RST_LOW.
  - en_i[1] → TX_SHIFT, and data_i is latched.
  - Both bits set in the same cycle: reset wins. The write is dropped and done_o[1] is never produced for it.
- **RST_LOW**
  - lcd_rst_o = 0 and lcd_cs_o = 1 for RST_LOW_CYC cycles, then → RST_WAIT.
- **RST_WAIT**
  - lcd_rst_o = 1 for RST_WAIT_CYC cycles, then → IDLE with a done_o[0] pulse.
- **TX_SHIFT**
  - lcd_cs_o = 0; lcd_dc_o = latched bit8.
  - Each bit occupies 2·CLK_DIV cycles: SCLK low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - MOSI changes only while SCLK is low, at the start of each bit. The panel samples on the rising edge.
  - Bit order is 7 down to 0. After the 8th high phase, SCLK returns low → TX_HOLD.
- **TX_HOLD**
  - CS stays low and SCLK low for CLK_DIV cycles.
  - Then lcd_cs_o = 1, done_o[1] pulses and the state returns to IDLE.
- **Output hold rules**
  - lcd_dc_o and lcd_mosi_o keep their last values in IDLE. They are don't-care while CS is high.
  - lcd_rst_o stays 1 outside RST_LOW.
- **Reset**
  - Reset values: lcd_rst_o = 1, lcd_cs_o = 1, lcd_sclk_o = 0, lcd_mosi_o = 0, lcd_dc_o = 0, done_o = 0, busy_o = 0, state IDLE.
  - Assertion mid-command aborts immediately (asynchronous) with no done pulse. After release the block idles; the panel pins go to their reset values, so CS deasserts.

## Timing
- Accept edge T0: the clk edge where the block is in IDLE with en_i ≠ 0.
- **Write**
  - From T0+1: lcd_cs_o = 0, busy_o = 1, lcd_dc_o = bit8, lcd_mosi_o = bit7, SCLK low.
  - First SCLK rise at T0+1+CLK_DIV.
  - Bit k is presented at T0+1+(7−k)·2·CLK_DIV.
  - Last SCLK fall at T0+1+16·CLK_DIV.
  - lcd_cs_o rises and done_o[1] = 1 for exactly one cycle at T0+1+17·CLK_DIV. With CLK_DIV = 2 that is T0+35.
- **Reset**
  - lcd_rst_o = 0 during T0+1 … T0+RST_LOW_CYC.
  - lcd_rst_o rises at T0+RST_LOW_CYC+1.
  - done_o[0] pulses at T0+RST_LOW_CYC+RST_WAIT_CYC+1.
- **Back-to-back**
  - busy_o deasserts in the same cycle done pulses.
  - A new en_i sampled in that done cycle is accepted, giving zero-gap chaining.
  - CS goes high for at least 1 cycle between writes.
- **Busy window**: busy_o is high from T0+1 through the cycle before done.
- **Pulses**: done_o bits never assert together and are never wider than one cycle.

## Test plan
- **Post-reset idle**: release rst_n with en_i = 0 for 20 cycles → all outputs hold their reset values and busy_o stays 0.
- **Single write**: CLK_DIV = 2, en_i = 2'b10, data_i = 9'h1A5.
  - Expect lcd_dc_o = 1 and 8 SCLK rises.
  - MOSI sampled on the rises reads 1,0,1,0,0,1,0,1.
  - done_o[1] pulses at T0+35 as CS rises.
- **Panel reset**: RST_LOW_CYC = 10, RST_WAIT_CYC = 20, en_i = 2'b01.
  - lcd_rst_o is low exactly 10 cycles.
  - done_o[0] pulses at T0+31.
  - CS stays high throughout.
- **Collision and busy-ignore**
  - en_i = 2'b11 → only the reset sequence runs and done_o[1] never fires.
  - en_i[1] pulsed mid-reset → ignored, no SCLK activity.
- **Chained writes**: issue 9'h02C (command) then 9'h1F8 (data), the second en_i in the done cycle.
  - Second CS low starts the next cycle.
  - DC reads 0 then 1.
  - Bytes 8'h2C and 8'hF8 are decoded correctly.
- **Abort**: assert rst_n low at bit 4 of a write → CS = 1, SCLK = 0 and no done pulse. A subsequent write completes normally.
